// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares the single cmd_proc command port between the UART host and the
// tour command sequencer. UART commands are queued in a small FIFO so the UART can keep
// streaming while the tour owns the port. Exactly one command is in flight at a time,
// from grant until send_resp, and the completion pulse is routed back to its issuer.
//
// Optional feature: define CMD_ARB_WATCHDOG_EN to add a WAIT_x timeout watchdog that
// forces IDLE after TMO_CYCLES and raises a sticky err flag.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_UART / cmd_rdy_UART     UART command + valid (held until clr_rdy_UART)
//   clr_rdy_UART                1-cycle pulse: UART command written into the FIFO
//   cmd_TC / cmd_rdy_TC         tour command + valid (held until clr_rdy_TC)
//   clr_rdy_TC                  1-cycle pulse: tour command taken by cmd_proc
//   tour_lock                   blocks UART grants (FIFO keeps filling)
//   cmd / cmd_rdy               registered command + valid to cmd_proc
//   clr_cmd_rdy                 cmd_proc consumed cmd
//   send_resp                   cmd_proc finished the in-flight command
//   resp_UART / resp_TC         1-cycle completion pulses to the issuer
//   fifo_full                   UART FIFO holds FIFO_DEPTH entries
//   err                         sticky watchdog timeout (0 without the watchdog)
module cmd_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_rdy_UART,
  input  logic [15:0] cmd_TC,
  input  logic        cmd_rdy_TC,
  output logic        clr_rdy_TC,
  input  logic        tour_lock,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        resp_UART,
  output logic        resp_TC,
  output logic        fifo_full,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TMO_CYCLES < 1) begin : g_bad_param
    $error("cmd_arbiter: unsupported FIFO_DEPTH/TMO_CYCLES");
  end

  typedef enum logic [2:0] {IDLE, GRANT_T, WAIT_T, GRANT_U, WAIT_U} state_t;
  state_t state;

  // ---------------- UART FIFO ----------------
  // Pointers carry one extra bit so full and empty differ on wrap-around.
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [15:0]   fifo_head;
  logic          fifo_empty, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = mem[rd_ptr[AW-1:0]];

  // clr_rdy_UART gating stops a second push while the wrapper is still dropping its valid.
  // fifo_full is the pre-pop value, so a push to a full FIFO waits a cycle.
  assign push = cmd_rdy_UART && !fifo_full && !clr_rdy_UART;
  assign pop  = (state == GRANT_U) && cmd_rdy && clr_cmd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      clr_rdy_UART <= 1'b0;
    end else begin
      clr_rdy_UART <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_UART;
  end

  // ---------------- watchdog ----------------
  logic tmo;
`ifdef CMD_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TMO_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            in_wait, err_q;

  assign in_wait = (state == WAIT_T) || (state == WAIT_U);
  // A same-cycle send_resp wins over the timeout.
  assign tmo     = in_wait && !send_resp && (wd_cnt == WD_W'(TMO_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (in_wait && !send_resp && !tmo) wd_cnt <= wd_cnt + 1'b1;
      else                               wd_cnt <= '0;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // ---------------- arbitration FSM ----------------
  // hold blocks arbitration for the first IDLE cycle after a command ends, so a requester
  // still dropping its valid (e.g. after clr_rdy_TC) is not granted a second time.
  logic hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
      clr_rdy_TC <= 1'b0;
      resp_UART  <= 1'b0;
      resp_TC    <= 1'b0;
      hold       <= 1'b0;
    end else begin
      clr_rdy_TC <= 1'b0;
      resp_UART  <= 1'b0;
      resp_TC    <= 1'b0;
      hold       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!hold) begin
            if (cmd_rdy_TC)                     state <= GRANT_T;
            else if (!fifo_empty && !tour_lock) state <= GRANT_U;
          end
        end
        GRANT_T, GRANT_U: begin
          // cmd_rdy is low only on the entry cycle: load the command then.
          if (!cmd_rdy) begin
            cmd     <= (state == GRANT_T) ? cmd_TC : fifo_head;
            cmd_rdy <= 1'b1;
          end else if (clr_cmd_rdy) begin
            cmd_rdy    <= 1'b0;
            clr_rdy_TC <= (state == GRANT_T);
            if (send_resp) begin
              state     <= IDLE;
              hold      <= 1'b1;
              resp_TC   <= (state == GRANT_T);
              resp_UART <= (state == GRANT_U);
            end else begin
              state <= (state == GRANT_T) ? WAIT_T : WAIT_U;
            end
          end
        end
        WAIT_T, WAIT_U: begin
          if (send_resp) begin
            state     <= IDLE;
            hold      <= 1'b1;
            resp_TC   <= (state == WAIT_T);
            resp_UART <= (state == WAIT_U);
          end else if (tmo) begin
            state <= IDLE;
            hold  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: UART/TC requester models feed command queues, a cmd_proc model
// serves grants and compares each against a scoreboard of expected commands.
module tb_cmd_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] cmd_UART = '0, cmd_TC = '0, cmd;
  logic        cmd_rdy_UART = 1'b0, cmd_rdy_TC = 1'b0, tour_lock = 1'b0;
  logic        clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic        clr_rdy_UART, clr_rdy_TC, cmd_rdy, resp_UART, resp_TC, fifo_full, err;

  always #5 clk = ~clk;

  cmd_arbiter #(.FIFO_DEPTH(4), .TMO_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_rdy_UART(clr_rdy_UART),
    .cmd_TC(cmd_TC), .cmd_rdy_TC(cmd_rdy_TC), .clr_rdy_TC(clr_rdy_TC),
    .tour_lock(tour_lock), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp_UART(resp_UART), .resp_TC(resp_TC), .fifo_full(fifo_full), .err(err)
  );

  typedef struct {bit tc; logic [15:0] cmd; int lat;} vec_t;

  logic [15:0] uart_q[$], tc_q[$], exp_u[$], exp_t[$];
  int checks = 0, errors = 0, cyc = 0;
  int clr_u_cnt = 0, clr_t_cnt = 0, resp_u_cnt = 0, resp_t_cnt = 0;
  int u_rise = 0, t_rise = 0, c_rise = 0;
  logic pu = 1'b0, pt = 1'b0, pc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pulse counters and rising-edge timestamps.
  always @(negedge clk) begin
    if (clr_rdy_UART) clr_u_cnt++;
    if (clr_rdy_TC)   clr_t_cnt++;
    if (resp_UART)    resp_u_cnt++;
    if (resp_TC)      resp_t_cnt++;
    if (cmd_rdy_UART && !pu) u_rise = cyc;
    if (cmd_rdy_TC && !pt)   t_rise = cyc;
    if (cmd_rdy && !pc)      c_rise = cyc;
    pu = cmd_rdy_UART; pt = cmd_rdy_TC; pc = cmd_rdy;
  end

  // Requester models: hold valid until the clear pulse, then take the next queued command.
  always @(posedge clk) begin
    #2;
    if (cmd_rdy_UART && clr_rdy_UART) cmd_rdy_UART = 1'b0;
    else if (!cmd_rdy_UART && uart_q.size() > 0) begin
      cmd_UART = uart_q.pop_front(); cmd_rdy_UART = 1'b1;
    end
    if (cmd_rdy_TC && clr_rdy_TC) cmd_rdy_TC = 1'b0;
    else if (!cmd_rdy_TC && tc_q.size() > 0) begin
      cmd_TC = tc_q.pop_front(); cmd_rdy_TC = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask

  task automatic wait_rdy();
    int n = 0;
    while (!cmd_rdy && n < 60) begin smp(); n++; end
    chk("grant_seen", cmd_rdy, 1);
  endtask

  task automatic push_u(input logic [15:0] c); uart_q.push_back(c); exp_u.push_back(c); endtask
  task automatic push_t(input logic [15:0] c); tc_q.push_back(c); exp_t.push_back(c); endtask

  // cmd_proc model: wait for a grant, score it, consume and complete it.
  task automatic serve(input bit tc, input bit both, input int lat);
    int ru, rt, ct;
    logic [15:0] e;
    wait_rdy();
    if (!cmd_rdy) return;
    if (tc) e = (exp_t.size() > 0) ? exp_t.pop_front() : 16'hxxxx;
    else    e = (exp_u.size() > 0) ? exp_u.pop_front() : 16'hxxxx;
    chk("grant_cmd", cmd, e);
    if (lat > 0) chk("latency", c_rise - (tc ? t_rise : u_rise), lat);
    ru = resp_u_cnt; rt = resp_t_cnt; ct = clr_t_cnt;
    drv(); clr_cmd_rdy = 1'b1; send_resp = both;
    drv(); clr_cmd_rdy = 1'b0; send_resp = !both;
    drv(); send_resp = 1'b0;
    repeat (2) smp();
    chk("cmd_rdy_drop", cmd_rdy, 0);
    chk("resp_uart_cnt", resp_u_cnt - ru, !tc);
    chk("resp_tc_cnt", resp_t_cnt - rt, tc);
    chk("clr_tc_cnt", clr_t_cnt - ct, tc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int cu0, ru, rt, n, t0;
    vecs[0] = '{0, 16'h2001, 3};
    vecs[1] = '{1, 16'h3BF1, 2};
    vecs[2] = '{0, 16'h0000, 3};
    vecs[3] = '{1, 16'hFFFF, 2};
    vecs[4] = '{0, 16'hA5A5, 3};
    vecs[5] = '{1, 16'h0001, 2};

    // Reset state
    repeat (3) smp();
    chk("reset_outs", {cmd, cmd_rdy, clr_rdy_UART, clr_rdy_TC, resp_UART, resp_TC, fifo_full, err}, 0);
    drv(); rst_n = 1'b1;
    repeat (3) smp();
    chk("post_reset_outs", {cmd, cmd_rdy, clr_rdy_UART, clr_rdy_TC, resp_UART, resp_TC, fifo_full, err}, 0);

    // Single transactions from both sources, with latency and routing
    for (int i = 0; i < 6; i++) begin
      cu0 = clr_u_cnt;
      drv();
      if (vecs[i].tc) push_t(vecs[i].cmd); else push_u(vecs[i].cmd);
      serve(vecs[i].tc, 1'b0, vecs[i].lat);
      chk("clr_uart_once", clr_u_cnt - cu0, !vecs[i].tc);
      repeat (3) drv();
    end

    // Stray clr_cmd_rdy/send_resp in IDLE are ignored
    ru = resp_u_cnt; rt = resp_t_cnt;
    drv(); clr_cmd_rdy = 1'b1; send_resp = 1'b1;
    drv(); clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    repeat (3) smp();
    chk("idle_stray_resp", (resp_u_cnt - ru) + (resp_t_cnt - rt), 0);
    chk("idle_stray_rdy", cmd_rdy, 0);

    // FIFO fill under tour_lock: 4 accepted, 5th held, then all issued in order
    drv(); tour_lock = 1'b1;
    cu0 = clr_u_cnt;
    for (int i = 0; i < 5; i++) push_u(16'h1000 + 16'(i));
    repeat (25) smp();
    chk("fifo_full_at4", fifo_full, 1);
    chk("clr_uart_4", clr_u_cnt - cu0, 4);
    chk("uart5_held", cmd_rdy_UART, 1);
    chk("locked_no_grant", cmd_rdy, 0);
    drv(); tour_lock = 1'b0;
    for (int i = 0; i < 5; i++) serve(1'b0, 1'b0, 0);
    chk("clr_uart_5", clr_u_cnt - cu0, 5);
    chk("fifo_drained", fifo_full, 0);

    // Tour priority over a waiting UART entry
    drv(); tour_lock = 1'b1;
    push_u(16'h2222);
    repeat (8) smp();
    drv(); push_t(16'h3BF1); tour_lock = 1'b0;
    serve(1'b1, 1'b0, 2);
    serve(1'b0, 1'b0, 0);

    // clr_cmd_rdy and send_resp together in GRANT_T
    repeat (3) drv();
    push_t(16'h5A5A);
    serve(1'b1, 1'b1, 2);
    repeat (4) smp();
    chk("no_regrant", cmd_rdy, 0);

    // Reset during WAIT_U with two entries queued
    drv(); tour_lock = 1'b1;
    cu0 = clr_u_cnt;
    push_u(16'h5001); push_u(16'h5002); push_u(16'h5003);
    repeat (12) smp();
    chk("rst_fill", clr_u_cnt - cu0, 3);
    drv(); tour_lock = 1'b0;
    wait_rdy();
    chk("rst_head", cmd, exp_u.pop_front());
    drv(); clr_cmd_rdy = 1'b1;
    drv(); clr_cmd_rdy = 1'b0;
    ru = resp_u_cnt; rt = resp_t_cnt;
    drv(); rst_n = 1'b0;
    smp();
    chk("midrst_outs", {cmd, cmd_rdy, clr_rdy_UART, clr_rdy_TC, resp_UART, resp_TC, fifo_full, err}, 0);
    drv(); rst_n = 1'b1;
    repeat (10) smp();
    chk("midrst_no_resp", (resp_u_cnt - ru) + (resp_t_cnt - rt), 0);
    chk("midrst_fifo_lost", cmd_rdy, 0);
    exp_u.delete();

    // Stalled command: watchdog (if built) or indefinite wait
    drv(); push_t(16'h4242);
    wait_rdy();
    chk("wd_cmd", cmd, exp_t.pop_front());
    ru = resp_u_cnt; rt = resp_t_cnt;
    drv(); clr_cmd_rdy = 1'b1;
    drv(); clr_cmd_rdy = 1'b0;
    smp(); t0 = cyc;
`ifdef CMD_ARB_WATCHDOG_EN
    n = 0;
    while (!err && n < 300) begin smp(); n++; end
    chk("wd_err", err, 1);
    chk("wd_cycles", cyc - t0, 100);
    repeat (3) smp();
    chk("wd_no_resp", (resp_u_cnt - ru) + (resp_t_cnt - rt), 0);
`else
    repeat (150) smp();
    chk("err_tied0", err, 0);
    chk("wait_no_resp", (resp_u_cnt - ru) + (resp_t_cnt - rt), 0);
    drv(); send_resp = 1'b1;
    drv(); send_resp = 1'b0;
    repeat (2) smp();
    chk("late_resp_tc", resp_t_cnt - rt, 1);
`endif
    repeat (3) drv();
    push_u(16'h6006);
    serve(1'b0, 1'b0, 3);
`ifdef CMD_ARB_WATCHDOG_EN
    chk("err_sticky", err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
